// File: rtl/vtiming_pkg.sv
// vtiming_pkg: shared phase encoding, 640x480@60 default timing and line/frame total helpers.
package vtiming_pkg;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;
  localparam int DEF_HACTIVE = 640;
  localparam int DEF_HFP     = 16;
  localparam int DEF_HSYNC   = 96;
  localparam int DEF_HBP     = 48;
  localparam int DEF_VACTIVE = 480;
  localparam int DEF_VFP     = 10;
  localparam int DEF_VSYNC   = 2;
  localparam int DEF_VBP     = 33;
  function automatic int calcTotal(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int hTotal(int act, int fp, int sync, int bp);
    return calcTotal(act, fp, sync, bp);
  endfunction
  function automatic int vTotal(int act, int fp, int sync, int bp);
    return calcTotal(act, fp, sync, bp);
  endfunction
endpackage

// File: rtl/vtiming_if.sv
// vtiming_if: video timing bundle; master = generator (drives sync/blank/position/strobes, samples Enable), slave = consumer.
interface vtiming_if #(parameter int XBITS = 10, parameter int YBITS = 10);
  logic             Enable;
  logic             OutHsync;
  logic             OutVsync;
  logic             Blank;
  logic [XBITS-1:0] PixelX;
  logic [YBITS-1:0] PixelY;
  logic             LineStart;
  logic             FrameStart;
  logic [15:0]      FrameCount;
  modport master (input Enable, output OutHsync, OutVsync, Blank, PixelX, PixelY, LineStart, FrameStart, FrameCount);
  modport slave (output Enable, input OutHsync, OutVsync, Blank, PixelX, PixelY, LineStart, FrameStart, FrameCount);
endinterface

// File: rtl/vtiming_axis.sv
// vtiming_axis: one timing axis -- position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Ports: PixelClkSrc/PixelRstN clock and async active-low reset; Step advances one position when Enable is high;
// Count is the position 0..TOTAL-1, State the current phase, Wrap pulses (comb) on the step leaving the last position.
module vtiming_axis
  import vtiming_pkg::*;
#(
  parameter int LEN_ACTIVE = DEF_HACTIVE,
  parameter int LEN_FP     = DEF_HFP,
  parameter int LEN_SYNC   = DEF_HSYNC,
  parameter int LEN_BP     = DEF_HBP,
  parameter int CBITS      = 10
) (
  input  logic             PixelClkSrc,
  input  logic             PixelRstN,
  input  logic             Step,
  input  logic             Enable,
  output logic [CBITS-1:0] Count,
  output phase_e           State,
  output logic             Wrap
);
  logic [CBITS-1:0] phaseCount;
  logic [CBITS-1:0] lastPhase;
  logic             adv;
  phase_e           nextState;
  always_ff @(posedge PixelClkSrc or negedge PixelRstN) begin
    if (!PixelRstN) begin
      State      <= ACTIVE;
      phaseCount <= '0;
      Count      <= '0;
    end else if (Step && Enable) begin
      State      <= nextState;
      phaseCount <= adv ? '0 : phaseCount + 1'b1;
      Count      <= Wrap ? '0 : Count + 1'b1;
    end
  end
  // phases are declared in traversal order, so +1 on the 2-bit code walks ACTIVE->FRONT->SYNC->BACK->ACTIVE
  always_comb nextState = adv ? phase_e'(State + 2'd1) : State;
  always_comb begin
    lastPhase = State == ACTIVE ? CBITS'(LEN_ACTIVE - 1) :
                State == FRONT  ? CBITS'(LEN_FP - 1) :
                State == SYNC   ? CBITS'(LEN_SYNC - 1) : CBITS'(LEN_BP - 1);
    adv       = Step && Enable && phaseCount == lastPhase;
    Wrap      = adv && State == BACK;
  end
endmodule

// File: rtl/vtiming_gen.sv
// vtiming_gen: parametrised video timing generator (sync, blank, pixel position, line/frame strobes).
// Ports: PixelClkSrc pixel clock; PixelRstN async active-low reset; vid (vtiming_if.master) carries Enable in and
// OutHsync/OutVsync/Blank/PixelX/PixelY/LineStart/FrameStart/FrameCount out, all registered with one cycle latency.
// Macro VTIMING_FRAMECNT_EN: when defined FrameCount counts FrameStart pulses, otherwise it is tied to 0.
module vtiming_gen
  import vtiming_pkg::*;
#(
  parameter int XBITS     = 10,
  parameter int YBITS     = 10,
  parameter int HACTIVE   = DEF_HACTIVE,
  parameter int HFP       = DEF_HFP,
  parameter int HSYNC     = DEF_HSYNC,
  parameter int HBP       = DEF_HBP,
  parameter int VACTIVE   = DEF_VACTIVE,
  parameter int VFP       = DEF_VFP,
  parameter int VSYNC     = DEF_VSYNC,
  parameter int VBP       = DEF_VBP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input logic      PixelClkSrc,
  input logic      PixelRstN,
  vtiming_if.master vid
);
  localparam int HTOTAL = hTotal(HACTIVE, HFP, HSYNC, HBP);
  localparam int VTOTAL = vTotal(VACTIVE, VFP, VSYNC, VBP);
  if (HACTIVE < 1 || HFP < 1 || HSYNC < 1 || HBP < 1 || VACTIVE < 1 || VFP < 1 || VSYNC < 1 || VBP < 1) begin : gBadLen
    $fatal(1, "vtiming_gen: every active/porch/sync length must be >= 1");
  end
  if (HTOTAL > 2 ** XBITS || VTOTAL > 2 ** YBITS) begin : gBadWidth
    $fatal(1, "vtiming_gen: HTOTAL/VTOTAL exceed counter width");
  end
  logic [XBITS-1:0] hCount;
  logic [YBITS-1:0] vCount;
  phase_e           hState;
  phase_e           vState;
  logic             hWrap;
  logic             unusedVWrap;
  logic             active;
  logic             frameHit;
  vtiming_axis #(.LEN_ACTIVE(HACTIVE), .LEN_FP(HFP), .LEN_SYNC(HSYNC), .LEN_BP(HBP), .CBITS(XBITS)) hAxis (
    .PixelClkSrc(PixelClkSrc), .PixelRstN(PixelRstN), .Step(vid.Enable), .Enable(vid.Enable),
    .Count(hCount), .State(hState), .Wrap(hWrap)
  );
  vtiming_axis #(.LEN_ACTIVE(VACTIVE), .LEN_FP(VFP), .LEN_SYNC(VSYNC), .LEN_BP(VBP), .CBITS(YBITS)) vAxis (
    .PixelClkSrc(PixelClkSrc), .PixelRstN(PixelRstN), .Step(hWrap && vid.Enable), .Enable(vid.Enable),
    .Count(vCount), .State(vState), .Wrap(unusedVWrap)
  );
  always_comb begin
    active   = hState == ACTIVE && vState == ACTIVE;
    frameHit = hCount == '0 && vCount == '0;
  end
  // outputs register the decode of the counters as they stand before this edge's advance
  always_ff @(posedge PixelClkSrc or negedge PixelRstN) begin
    if (!PixelRstN) begin
      vid.Blank      <= 1'b1;
      vid.OutHsync   <= !HSYNC_POL;
      vid.OutVsync   <= !VSYNC_POL;
      vid.PixelX     <= '0;
      vid.PixelY     <= '0;
      vid.LineStart  <= 1'b0;
      vid.FrameStart <= 1'b0;
    end else if (vid.Enable) begin
      vid.Blank      <= !active;
      vid.OutHsync   <= hState == SYNC ? HSYNC_POL : !HSYNC_POL;
      vid.OutVsync   <= vState == SYNC ? VSYNC_POL : !VSYNC_POL;
      vid.LineStart  <= hCount == '0;
      vid.FrameStart <= frameHit;
      if (active) begin
        vid.PixelX <= hCount;
        vid.PixelY <= vCount;
      end
    end else begin
      vid.LineStart  <= 1'b0;
      vid.FrameStart <= 1'b0;
    end
  end
`ifdef VTIMING_FRAMECNT_EN
  always_ff @(posedge PixelClkSrc or negedge PixelRstN) begin
    if (!PixelRstN) vid.FrameCount <= '0;
    else if (vid.Enable && frameHit) vid.FrameCount <= vid.FrameCount + 16'd1;
  end
`else
  assign vid.FrameCount = '0;
`endif
endmodule

// File: tb/tb_vtiming_gen.sv
// tb_vtiming_gen: randomized-enable bench for a small positive-polarity mode against a position-arithmetic model.
module tb_vtiming_gen;
  localparam int  HA = 8, HF = 2, HS = 2, HB = 2, VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int  HT = HA + HF + HS + HB;
  localparam int  VT = VA + VF + VS + VB;
  localparam bit  HPOL = 1'b1, VPOL = 1'b1;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   h, v, eX, eY, eFc;
  logic eBlank, eHs, eVs, eLs, eFs;
  vtiming_if #(.XBITS(4), .YBITS(4)) vid ();
  vtiming_gen #(
    .XBITS(4), .YBITS(4), .HACTIVE(HA), .HFP(HF), .HSYNC(HS), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VSYNC(VS), .VBP(VB), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .PixelClkSrc(clk), .PixelRstN(rstN), .vid(vid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, h, v, $time);
    end
  endtask
  task automatic checkAll();
    check("blank", 32'(vid.Blank), 32'(eBlank));
    check("hsync", 32'(vid.OutHsync), 32'(eHs));
    check("vsync", 32'(vid.OutVsync), 32'(eVs));
    check("pixelx", 32'(vid.PixelX), 32'(eX));
    check("pixely", 32'(vid.PixelY), 32'(eY));
    check("linestart", 32'(vid.LineStart), 32'(eLs));
    check("framestart", 32'(vid.FrameStart), 32'(eFs));
    check("framecount", 32'(vid.FrameCount), 32'(eFc));
  endtask
  task automatic modelReset();
    h = 0; v = 0; eX = 0; eY = 0; eFc = 0;
    eBlank = 1'b1; eHs = !HPOL; eVs = !VPOL; eLs = 1'b0; eFs = 1'b0;
  endtask
  // h/v is the position about to be shown; an enabled edge publishes it and moves on
  task automatic modelEdge(input logic en);
    if (en) begin
      eBlank = !(h < HA && v < VA);
      eHs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
      eVs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
      if (!eBlank) begin
        eX = h;
        eY = v;
      end
      eLs = h == 0;
      eFs = h == 0 && v == 0;
`ifdef VTIMING_FRAMECNT_EN
      if (eFs) eFc = (eFc + 1) % 65536;
`endif
      h++;
      if (h == HT) begin
        h = 0;
        v = (v + 1) % VT;
      end
    end else begin
      eLs = 1'b0;
      eFs = 1'b0;
    end
  endtask
  task automatic step(input logic en);
    vid.Enable = en;
    @(posedge clk);
    if (!rstN) modelReset();
    else modelEdge(en);
    @(negedge clk);
    checkAll();
  endtask
  initial begin
    vid.Enable = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll();
    rstN = 1'b1;
    repeat (3 * HT * VT) step(1'b1);
    repeat (5) step(1'b1);
    repeat (37) step(1'b0);
    repeat (2 * HT * VT) step(1'b1);
    repeat (1500) step(1'($urandom_range(0, 3) != 0));
    vid.Enable = 1'b1;
    @(posedge clk);
    modelEdge(1'b1);
    #2 rstN = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    repeat (2) step(1'b1);
    rstN = 1'b1;
    repeat (2 * HT * VT) step(1'b1);
    repeat (800) step(1'($urandom_range(0, 1) != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
